// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator sharing one counter.
// Each channel takes a signed sample, adds an offset and saturates it into a
// duty value held in a shadow register. The shadow duty is copied into the
// active duty at each period start. Edge- or center-aligned counting is
// selected per period, enable gates the whole block, and saturation events
// are recorded in sticky flags.
module pwm_multi #(
    parameter int NUM_CH        = 2,
    parameter int DATA_WIDTH    = 12,
    parameter int COUNTER_WIDTH = 10,
    parameter int OFFSET        = 512
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         enable,
    input  logic                         mode,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         data_valid,
    input  logic                         sat_clr,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic                         period_start,
    output logic [NUM_CH-1:0]            sat_flag
);

    // Duty needs one extra bit so that 2^COUNTER_WIDTH (always high) fits.
    localparam int DUTY_W    = COUNTER_WIDTH + 1;
    // Sum width is wide enough for both the sample and the full-scale duty.
    localparam int SUM_W     = ((DATA_WIDTH > COUNTER_WIDTH) ? DATA_WIDTH : COUNTER_WIDTH) + 2;
    localparam int DUTY_FULL = 32'sd1 <<< COUNTER_WIDTH;

    localparam logic signed [SUM_W-1:0]    OFFSET_S   = SUM_W'(OFFSET);
    localparam logic signed [SUM_W-1:0]    DUTY_MAX_S = SUM_W'(DUTY_FULL);
    localparam logic signed [SUM_W-1:0]    SUM_ZERO   = {SUM_W{1'b0}};
    localparam logic [DUTY_W-1:0]          DUTY_TOP   = DUTY_W'(DUTY_FULL);
    localparam logic [DUTY_W-1:0]          DUTY_ZERO  = {DUTY_W{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0]   CNT_ZERO   = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0]   CNT_ONE    = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0]   CNT_MAX    = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0]   CNT_MAX_M1 = CNT_MAX - CNT_ONE;
    localparam logic [NUM_CH-1:0]          CH_ZERO    = {NUM_CH{1'b0}};

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Offset and saturate one sample; returns {saturated, duty}.
    function automatic logic [DUTY_W:0] clamp_duty(input logic [DATA_WIDTH-1:0] sample);
        logic signed [SUM_W-1:0] sum;
        logic [DUTY_W:0]         result;
        sum = $signed({{(SUM_W-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample}) + OFFSET_S;
        if (sum < SUM_ZERO) begin
            result = {1'b1, DUTY_ZERO};
        end else if (sum > DUTY_MAX_S) begin
            result = {1'b1, DUTY_TOP};
        end else begin
            result = {1'b0, sum[DUTY_W-1:0]};
        end
        return result;
    endfunction

    // Shared counter state
    logic [COUNTER_WIDTH-1:0] counter_r;
    logic [COUNTER_WIDTH-1:0] counter_nxt_s;
    dir_t                     dir_r;
    dir_t                     dir_nxt_s;
    dir_t                     dir_eff_s;
    mode_t                    active_mode_r;
    mode_t                    eff_mode_s;
    logic                     at_zero_s;
    logic                     period_start_s;

    // Per-channel duty state
    logic [NUM_CH-1:0][DUTY_W-1:0] shadow_r;
    logic [NUM_CH-1:0][DUTY_W-1:0] active_r;
    logic [NUM_CH-1:0][DUTY_W-1:0] load_duty_s;
    logic [NUM_CH-1:0][DUTY_W-1:0] eff_duty_s;
    logic [NUM_CH-1:0]             load_sat_s;
    logic [NUM_CH-1:0]             cmp_s;

    // Period-start decode: at counter zero the incoming mode and an upward
    // direction govern the step, so a new mode takes effect from cycle one.
    always_comb begin
        at_zero_s      = (counter_r == CNT_ZERO);
        period_start_s = enable & at_zero_s;
        eff_mode_s     = active_mode_r;
        dir_eff_s      = dir_r;
        if (at_zero_s) begin
            eff_mode_s = mode_t'(mode);
            dir_eff_s  = DIR_UP;
        end else begin
            eff_mode_s = active_mode_r;
            dir_eff_s  = dir_r;
        end
    end

    // Next counter value and direction for edge (sawtooth) or center (triangle) counting.
    always_comb begin
        counter_nxt_s = counter_r;
        dir_nxt_s     = dir_r;
        if (!enable) begin
            counter_nxt_s = CNT_ZERO;
            dir_nxt_s     = DIR_UP;
        end else begin
            case (eff_mode_s)
                MODE_EDGE: begin
                    dir_nxt_s = DIR_UP;
                    if (counter_r == CNT_MAX) begin
                        counter_nxt_s = CNT_ZERO;
                    end else begin
                        counter_nxt_s = counter_r + CNT_ONE;
                    end
                end
                MODE_CENTER: begin
                    case (dir_eff_s)
                        DIR_UP: begin
                            if (counter_r == CNT_MAX) begin
                                counter_nxt_s = CNT_MAX_M1;
                                dir_nxt_s     = DIR_DOWN;
                            end else begin
                                counter_nxt_s = counter_r + CNT_ONE;
                                dir_nxt_s     = DIR_UP;
                            end
                        end
                        DIR_DOWN: begin
                            counter_nxt_s = counter_r - CNT_ONE;
                            if (counter_r == CNT_ONE) begin
                                dir_nxt_s = DIR_UP;
                            end else begin
                                dir_nxt_s = DIR_DOWN;
                            end
                        end
                        default: begin
                            counter_nxt_s = CNT_ZERO;
                            dir_nxt_s     = DIR_UP;
                        end
                    endcase
                end
                default: begin
                    counter_nxt_s = CNT_ZERO;
                    dir_nxt_s     = DIR_UP;
                end
            endcase
        end
    end

    // Per-channel saturating duty conversion and compare; the shadow duty is
    // used at counter zero so a fresh load shows in the very first cycle.
    always_comb begin
        load_duty_s = {(NUM_CH*DUTY_W){1'b0}};
        load_sat_s  = CH_ZERO;
        eff_duty_s  = {(NUM_CH*DUTY_W){1'b0}};
        cmp_s       = CH_ZERO;
        for (int k = 0; k < NUM_CH; k++) begin
            {load_sat_s[k], load_duty_s[k]} = clamp_duty(data_in[k*DATA_WIDTH +: DATA_WIDTH]);
            if (at_zero_s) begin
                eff_duty_s[k] = shadow_r[k];
            end else begin
                eff_duty_s[k] = active_r[k];
            end
            cmp_s[k] = ({1'b0, counter_r} < eff_duty_s[k]);
        end
    end

    // Counter and direction register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter_r <= CNT_ZERO;
            dir_r     <= DIR_UP;
        end else begin
            counter_r <= counter_nxt_s;
            dir_r     <= dir_nxt_s;
        end
    end

    // Latch the mode and shadow duties into the active set at period start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_mode_r <= MODE_EDGE;
            active_r      <= {(NUM_CH*DUTY_W){1'b0}};
        end else if (period_start_s) begin
            active_mode_r <= eff_mode_s;
            active_r      <= shadow_r;
        end
    end

    // Shadow duty load; accepted whether or not the PWM is enabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_r <= {(NUM_CH*DUTY_W){1'b0}};
        end else if (data_valid) begin
            shadow_r <= load_duty_s;
        end
    end

    // Sticky saturation flags; a new saturation beats a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_flag <= CH_ZERO;
        end else begin
            sat_flag <= (sat_flag & ~{NUM_CH{sat_clr}}) | (data_valid ? load_sat_s : CH_ZERO);
        end
    end

    // Registered PWM pins and period-start strobe, forced low while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_out      <= CH_ZERO;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= enable ? cmp_s : CH_ZERO;
            period_start <= period_start_s;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi (COUNTER_WIDTH=4, DATA_WIDTH=8, OFFSET=8).
// Expected waveforms are derived from the loaded duty values and the
// edge/center counting pattern; each period is checked cycle by cycle.
module tb_pwm_multi;

    localparam int NCH   = 2;
    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int OFS   = 8;
    localparam int EDGE_N = 16;   // 2^CW
    localparam int CTR_N  = 30;   // 2*(2^CW-1)
    localparam int MAXC   = 15;

    logic              clk;
    logic              rstn;
    logic              enable;
    logic              mode;
    logic [NCH*DW-1:0] data_in;
    logic              data_valid;
    logic              sat_clr;
    logic [NCH-1:0]    pwm_out;
    logic              period_start;
    logic [NCH-1:0]    sat_flag;

    int n_checks;
    int n_fail;

    pwm_multi #(
        .NUM_CH       (NCH),
        .DATA_WIDTH   (DW),
        .COUNTER_WIDTH(CW),
        .OFFSET       (OFS)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .mode        (mode),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .sat_clr     (sat_clr),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pk(input int c0, input int c1);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(c0);
        b = 8'(c1);
        return {b, a};
    endfunction

    // One load cycle with optional simultaneous sat_clr.
    task automatic load(input int c0, input int c1, input logic clr);
        data_in    = pk(c0, c1);
        data_valid = 1'b1;
        sat_clr    = clr;
        tick();
        data_valid = 1'b0;
        sat_clr    = 1'b0;
    endtask

    // Check one full period starting from counter==0. The mode input is
    // changed to next_mode mid-period (phase 3) and up to two mid-period
    // loads may be issued; none of these may alter the current period.
    task automatic check_period(input string tag, input bit center, input int d0, input int d1,
                                input bit next_mode,
                                input int ld1_ph, input logic [15:0] ld1_data,
                                input int ld2_ph, input logic [15:0] ld2_data);
        int         n_cyc;
        int         tri_v;
        logic [2:0] exp_v;
        n_cyc = center ? CTR_N : EDGE_N;
        for (int p = 0; p < n_cyc; p++) begin
            tick();
            tri_v = (center && p > MAXC) ? (CTR_N - p) : p;
            exp_v = {(p == 0), (tri_v < d1), (tri_v < d0)};
            check($sformatf("%s p%0d {ps,pwm}", tag, p), {29'd0, period_start, pwm_out}, {29'd0, exp_v});
            if (p == 3) mode = next_mode;
            if (p == ld1_ph) begin
                data_in    = ld1_data;
                data_valid = 1'b1;
            end else if (p == ld2_ph) begin
                data_in    = ld2_data;
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
        end
        data_valid = 1'b0;
    endtask

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rstn       = 1'b0;
        enable     = 1'b0;
        mode       = 1'b0;
        data_in    = 16'd0;
        data_valid = 1'b0;
        sat_clr    = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset pwm_out", {30'd0, pwm_out}, 32'd0);
        check("reset period_start", {31'd0, period_start}, 32'd0);
        check("reset sat_flag", {30'd0, sat_flag}, 32'd0);
        rstn = 1'b1;
        tick();

        // Load while disabled: ch0=0 -> duty 8, ch1=4 -> duty 12
        load(0, 4, 1'b0);
        check("load no sat", {30'd0, sat_flag}, 32'd0);
        check("disabled outputs", {29'd0, period_start, pwm_out}, 32'd0);

        // Edge mode; two mid-period loads, the last (ch0=-8 -> 0, ch1=8 -> 16) wins
        mode   = 1'b0;
        enable = 1'b1;
        check_period("edgeA", 1'b0, 8, 12, 1'b0, 5, pk(4, -8), 9, pk(-8, 8));
        check("edgeA sat", {30'd0, sat_flag}, 32'd0);

        // Duty 0 / full duty; mode flip to center is deferred; load 8/8
        check_period("edgeB", 1'b0, 0, 16, 1'b1, 6, pk(0, 0), -1, 16'd0);

        // Center mode duty 8: 15 high cycles; load ch0=+100 (sat to 16), ch1=4
        check_period("ctrC", 1'b1, 8, 8, 1'b1, 10, pk(100, 4), -1, 16'd0);
        check("ctrC sat", {30'd0, sat_flag}, 32'd1);

        // Center mode full duty and duty 12; flip back to edge mid-period
        check_period("ctrD", 1'b1, 16, 12, 1'b0, -1, 16'd0, -1, 16'd0);
        check_period("edgeE", 1'b0, 16, 12, 1'b0, -1, 16'd0, -1, 16'd0);

        // Drop enable mid-period
        repeat (4) tick();
        check("pre disable", {29'd0, period_start, pwm_out}, 32'd3);
        enable = 1'b0;
        tick();
        check("disable next cycle", {29'd0, period_start, pwm_out}, 32'd0);
        repeat (3) tick();
        check("disable held", {29'd0, period_start, pwm_out}, 32'd0);

        // Sticky flags while disabled
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat clear", {30'd0, sat_flag}, 32'd0);
        load(100, -128, 1'b0);
        check("sat both", {30'd0, sat_flag}, 32'd3);
        load(0, 100, 1'b1);
        check("sat set wins", {30'd0, sat_flag}, 32'd2);

        // Re-enable: first enabled cycle is a period start with duties 8/16
        enable = 1'b1;
        check_period("reen", 1'b0, 8, 16, 1'b0, -1, 16'd0, -1, 16'd0);

        // Asynchronous reset in the high phase, no clock edge needed
        tick();
        check("pre reset", {29'd0, period_start, pwm_out}, 32'd7);
        rstn = 1'b0;
        #2;
        check("async reset outputs", {29'd0, period_start, pwm_out}, 32'd0);
        check("async reset sat", {30'd0, sat_flag}, 32'd0);
        #1;
        rstn = 1'b1;

        // After release: duty 0 until a new load reaches a period start
        check_period("post_rst", 1'b0, 0, 0, 1'b0, 4, pk(0, 4), -1, 16'd0);
        check_period("post_ld", 1'b0, 8, 12, 1'b0, -1, 16'd0, -1, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
